// File: rtl/jtflane_pcm_fetch.sv
// Purpose : byte fetcher for one PCM channel; keeps CUR, prefetches CUR+1 into NXT
//           (prefetch built only with JTFLANE_PCM_PREFETCH_EN defined).
// Latency : hit data one cycle after pcm_addr; a miss costs a guard cycle plus ROM latency.
// Backpr. : holds rom_cs/rom_addr until rom_ok is accepted; pcm_ok stays low while missing.
module jtflane_pcm_fetch #(
  parameter int AW   = 17,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   pcm_addr,
  output logic [7:0]      pcm_dout,
  output logic            pcm_ok,
  output logic            rom_cs,
  output logic [AW-1:0]   rom_addr,
  input  logic [7:0]      rom_data,
  input  logic            rom_ok,
  output logic [CNTW-1:0] miss_cnt
);

  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, FETCH, PREF} state_t;

  state_t        state, state_nxt;

  logic [AW-1:0] cur_addr;
  logic [7:0]    cur_data;
  logic          cur_v;

  // Set for exactly one cycle after rom_addr is loaded so a stale rom_ok is ignored
  logic          guard;

  logic          cur_hit, nxt_hit, busy_same, accept, demand_miss;
  logic          fill_cur, load;
  logic [AW-1:0] load_addr;

`ifdef JTFLANE_PCM_PREFETCH_EN
  logic [AW-1:0] nxt_addr;
  logic [7:0]    nxt_data;
  logic          nxt_v;
  logic          fill_nxt, promote;

  assign nxt_hit = nxt_v && (nxt_addr == pcm_addr);
`else
  assign nxt_hit = 1'b0;
`endif

  assign rom_cs      = (state != IDLE);
  assign cur_hit     = cur_v && (cur_addr == pcm_addr);
  // Still waiting on the very address being asked for: not a new miss
  assign busy_same   = (state == FETCH) && (rom_addr == pcm_addr);
  assign accept      = rom_cs && rom_ok && !guard;
  // A fill in progress takes priority; the compare resumes next cycle on updated entries
  assign demand_miss = !cur_hit && !nxt_hit && !busy_same && !accept;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and datapath controls: fill beats promote beats demand miss
  always_comb begin
    state_nxt = state;
    fill_cur  = 1'b0;
    load      = 1'b0;
    load_addr = rom_addr;
`ifdef JTFLANE_PCM_PREFETCH_EN
    fill_nxt  = 1'b0;
    promote   = 1'b0;
`endif
    if (accept) begin
      if (state == FETCH) begin
        fill_cur  = 1'b1;
`ifdef JTFLANE_PCM_PREFETCH_EN
        state_nxt = PREF;
        load      = 1'b1;
        load_addr = rom_addr + ADDR_ONE;
`else
        state_nxt = IDLE;
`endif
      end else begin
`ifdef JTFLANE_PCM_PREFETCH_EN
        fill_nxt  = 1'b1;
`endif
        state_nxt = IDLE;
      end
    end
`ifdef JTFLANE_PCM_PREFETCH_EN
    else if (nxt_hit) begin
      promote   = 1'b1;
      state_nxt = PREF;
      load      = 1'b1;
      load_addr = nxt_addr + ADDR_ONE;
    end
`endif
    else if (demand_miss) begin
      state_nxt = FETCH;
      load      = 1'b1;
      load_addr = pcm_addr;
    end
  end

  // ROM address, guard cycle and miss counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      guard    <= 1'b0;
      miss_cnt <= '0;
    end else begin
      guard <= load;
      if (load) rom_addr <= load_addr;
      if (demand_miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
    end
  end

  // CUR entry: filled by a demand fetch, or promoted from NXT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr <= '0;
      cur_data <= '0;
      cur_v    <= 1'b0;
    end else if (fill_cur) begin
      cur_addr <= rom_addr;
      cur_data <= rom_data;
      cur_v    <= 1'b1;
`ifdef JTFLANE_PCM_PREFETCH_EN
    end else if (promote) begin
      cur_addr <= nxt_addr;
      cur_data <= nxt_data;
      cur_v    <= 1'b1;
`endif
    end else if (demand_miss) begin
      cur_v    <= 1'b0;
    end
  end

`ifdef JTFLANE_PCM_PREFETCH_EN
  // NXT entry: filled by the prefetch, consumed when promoted into CUR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nxt_addr <= '0;
      nxt_data <= '0;
      nxt_v    <= 1'b0;
    end else if (fill_nxt) begin
      nxt_addr <= rom_addr;
      nxt_data <= rom_data;
      nxt_v    <= 1'b1;
    end else if (promote || demand_miss) begin
      nxt_v    <= 1'b0;
    end
  end
`endif

  // Registered sample output for the address presented last cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm_ok   <= 1'b0;
      pcm_dout <= '0;
    end else begin
      pcm_ok <= cur_hit || nxt_hit;
      if (cur_hit) begin
        pcm_dout <= cur_data;
`ifdef JTFLANE_PCM_PREFETCH_EN
      end else if (nxt_hit) begin
        pcm_dout <= nxt_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_jtflane_pcm_fetch.sv
// Bench for jtflane_pcm_fetch: directed scenarios against a behavioural slot model.
// Expectations follow JTFLANE_PCM_PREFETCH_EN the same way the design does.
// The slot model raises rom_ok a fixed number of cycles after rom_addr settles.
module tb_jtflane_pcm_fetch;
  localparam int AW   = 17;
  localparam int CNTW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   pcm_addr = '0;
  logic [7:0]      pcm_dout;
  logic            pcm_ok;
  logic            rom_cs;
  logic [AW-1:0]   rom_addr;
  logic [7:0]      rom_data = '0;
  logic            rom_ok = 1'b0;
  logic [CNTW-1:0] miss_cnt;

  int errors = 0;
  int checks = 0;
  int rom_lat = 6;
  bit rom_sticky = 1'b0;

  jtflane_pcm_fetch #(.AW(AW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .pcm_addr(pcm_addr), .pcm_dout(pcm_dout), .pcm_ok(pcm_ok),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
    .miss_cnt(miss_cnt)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h4A ^ {7'b0, a[16]};
  endfunction

  // Slot model. Sticky mode keeps rom_ok high and shows stale data the cycle the address moves.
  initial begin : rom_model
    logic [AW-1:0] last;
    int cnt;
    last = '0;
    cnt  = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n || !rom_cs || rom_addr != last) cnt = 0;
      else cnt++;
      if (rom_sticky) begin
        rom_ok   = 1'b1;
        rom_data = (rom_addr != last) ? 8'hEE : rom_val(rom_addr);
      end else begin
        rom_ok   = rst_n && rom_cs && (cnt >= rom_lat);
        rom_data = rom_val(rom_addr);
      end
      last = rom_addr;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset(input logic [AW-1:0] a);
    rst_n = 1'b0;
    pcm_addr = a;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    int i;
    rom_lat = 6;
    rst_n = 1'b0;
    pcm_addr = 17'h01000;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pcm_ok !== 1'b0) begin errors++; $display("FAIL reset_pcm_ok: got %0b want 0", pcm_ok); end
    checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL reset_rom_cs: got %0b want 0", rom_cs); end
    checks++; if (miss_cnt !== 16'd0) begin errors++; $display("FAIL reset_miss_cnt: got %0d want 0", miss_cnt); end
    checks++; if (rom_addr !== 17'h0 || pcm_dout !== 8'h00) begin
      errors++; $display("FAIL reset_addr_dout: got addr %h dout %h want 0 0", rom_addr, pcm_dout); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (i = 0; i < 60; i++) begin
      if (pcm_ok === 1'b1) break;
      @(posedge clk); #1;
    end
    checks++; if (pcm_ok !== 1'b1) begin errors++; $display("FAIL reset_first_fill: pcm_ok %0b want 1", pcm_ok); end
    pcm_addr = 17'h02000;
    repeat (3) begin @(posedge clk); #1; end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (rom_cs !== 1'b0 || pcm_ok !== 1'b0 || miss_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_mid_fetch: cs %0b ok %0b miss %0d want 0 0 0", rom_cs, pcm_ok, miss_cnt); end
    pcm_addr = 17'h01000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (pcm_ok !== 1'b0) begin errors++; $display("FAIL reset_entries_invalid: pcm_ok %0b want 0", pcm_ok); end
  endtask

  task automatic test_fetch;
    int i, cs_bad;
    cs_bad = 0;
    rom_lat = 6;
    apply_reset(17'h01000);
    for (i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i <= 6 && (rom_cs !== 1'b1 || rom_addr !== 17'h01000)) cs_bad++;
      if (pcm_ok === 1'b1) break;
    end
    checks++; if (cs_bad !== 0) begin errors++; $display("FAIL fetch_cs_hold: %0d bad cycles want 0", cs_bad); end
    checks++; if (pcm_ok !== 1'b1 || i !== 9) begin
      errors++; $display("FAIL fetch_latency: ok %0b at cycle %0d want 1 at 9", pcm_ok, i); end
    checks++; if (pcm_dout !== 8'h5A) begin errors++; $display("FAIL fetch_data: got %h want 5a", pcm_dout); end
    checks++; if (miss_cnt !== 16'd1) begin errors++; $display("FAIL fetch_miss_cnt: got %0d want 1", miss_cnt); end
`ifdef JTFLANE_PCM_PREFETCH_EN
    checks++; if (rom_cs !== 1'b1 || rom_addr !== 17'h01001) begin
      errors++; $display("FAIL fetch_pref_addr: cs %0b addr %h want 1 01001", rom_cs, rom_addr); end
`else
    checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL fetch_idle_after: cs %0b want 0", rom_cs); end
`endif
  endtask

  task automatic test_seq;
    int i, drops, bad;
    logic [CNTW-1:0] exp_miss;
    drops = 0;
    bad = 0;
`ifdef JTFLANE_PCM_PREFETCH_EN
    exp_miss = 16'd1;
`else
    exp_miss = 16'd256;
`endif
    rom_lat = 5;
    apply_reset(17'h01000);
    for (i = 0; i < 60; i++) begin
      if (pcm_ok === 1'b1) break;
      @(posedge clk); #1;
    end
    checks++; if (pcm_ok !== 1'b1) begin errors++; $display("FAIL seq_first_byte: pcm_ok %0b want 1", pcm_ok); end
    repeat (8) begin @(posedge clk); #1; end
    for (int a = 1; a < 256; a++) begin
      pcm_addr = AW'(32'h1000 + a);
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        if (pcm_ok !== 1'b1) drops++;
      end
      if (pcm_ok !== 1'b1 || pcm_dout !== rom_val(pcm_addr)) bad++;
    end
`ifdef JTFLANE_PCM_PREFETCH_EN
    checks++; if (drops !== 0) begin errors++; $display("FAIL seq_ok_drops: %0d cycles low want 0", drops); end
`endif
    checks++; if (bad !== 0) begin errors++; $display("FAIL seq_data: %0d bad bytes want 0", bad); end
    checks++; if (miss_cnt !== exp_miss) begin errors++; $display("FAIL seq_miss_cnt: got %0d want %0d", miss_cnt, exp_miss); end
  endtask

  task automatic test_guard;
    int i, stale;
    stale = 0;
    rom_sticky = 1'b1;
    apply_reset(17'h00345);
    for (i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (pcm_ok === 1'b1 && pcm_dout === 8'hEE) stale++;
    end
    checks++; if (pcm_ok !== 1'b1 || pcm_dout !== 8'h0C) begin
      errors++; $display("FAIL guard_first: ok %0b dout %h want 1 0c", pcm_ok, pcm_dout); end
    pcm_addr = 17'h00789;
    for (i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (pcm_ok === 1'b1 && pcm_dout === 8'hEE) stale++;
    end
    checks++; if (pcm_ok !== 1'b1 || pcm_dout !== 8'hC4) begin
      errors++; $display("FAIL guard_second: ok %0b dout %h want 1 c4", pcm_ok, pcm_dout); end
    checks++; if (stale !== 0) begin errors++; $display("FAIL guard_stale_fill: %0d stale cycles want 0", stale); end
    rom_sticky = 1'b0;
  endtask

  task automatic test_abort;
    int i;
    rom_lat = 10;
    apply_reset(17'h01000);
    for (i = 0; i < 60; i++) begin
      if (pcm_ok === 1'b1) break;
      @(posedge clk); #1;
    end
    checks++; if (pcm_ok !== 1'b1 || miss_cnt !== 16'd1) begin
      errors++; $display("FAIL abort_setup: ok %0b miss %0d want 1 1", pcm_ok, miss_cnt); end
    pcm_addr = 17'h00200;
    @(posedge clk); #1;
    checks++; if (rom_cs !== 1'b1 || rom_addr !== 17'h00200) begin
      errors++; $display("FAIL abort_rom_addr: cs %0b addr %h want 1 00200", rom_cs, rom_addr); end
    checks++; if (miss_cnt !== 16'd2) begin errors++; $display("FAIL abort_miss_cnt: got %0d want 2", miss_cnt); end
    for (i = 0; i < 60; i++) begin
      if (pcm_ok === 1'b1) break;
      @(posedge clk); #1;
    end
    checks++; if (pcm_ok !== 1'b1 || pcm_dout !== 8'h48 || miss_cnt !== 16'd2) begin
      errors++; $display("FAIL abort_refill: ok %0b dout %h miss %0d want 1 48 2", pcm_ok, pcm_dout, miss_cnt); end
  endtask

  task automatic test_wrap;
    int i, drops;
    logic [CNTW-1:0] exp_miss;
    drops = 0;
`ifdef JTFLANE_PCM_PREFETCH_EN
    exp_miss = 16'd1;
`else
    exp_miss = 16'd2;
`endif
    rom_lat = 4;
    apply_reset(17'h1FFFF);
    for (i = 0; i < 60; i++) begin
      if (pcm_ok === 1'b1) break;
      @(posedge clk); #1;
    end
    checks++; if (pcm_ok !== 1'b1 || pcm_dout !== 8'h4B) begin
      errors++; $display("FAIL wrap_top_byte: ok %0b dout %h want 1 4b", pcm_ok, pcm_dout); end
`ifdef JTFLANE_PCM_PREFETCH_EN
    checks++; if (rom_cs !== 1'b1 || rom_addr !== 17'h00000) begin
      errors++; $display("FAIL wrap_pref_addr: cs %0b addr %h want 1 00000", rom_cs, rom_addr); end
`endif
    repeat (10) begin @(posedge clk); #1; end
    pcm_addr = 17'h00000;
    for (i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (pcm_ok !== 1'b1) drops++;
    end
`ifdef JTFLANE_PCM_PREFETCH_EN
    checks++; if (drops !== 0) begin errors++; $display("FAIL wrap_ok_drops: %0d cycles low want 0", drops); end
`endif
    checks++; if (pcm_ok !== 1'b1 || pcm_dout !== 8'h4A) begin
      errors++; $display("FAIL wrap_zero_byte: ok %0b dout %h want 1 4a", pcm_ok, pcm_dout); end
    checks++; if (miss_cnt !== exp_miss) begin errors++; $display("FAIL wrap_miss_cnt: got %0d want %0d", miss_cnt, exp_miss); end
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_seq;
    test_guard;
    test_abort;
    test_wrap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
